sqrt_ctrl: RTL and testbench
============================

// Module: sqrt_ctrl
// PURPOSE
//  FSM controller that sequences the 16-bit integer square-root datapath (a/sq/del/out regs, lteflg compare).
//  Takes a start request, drives load strobes and per-job init of sq/del, and signals done when root is valid.
//  Sits between the normalization control logic (requester) and the square-root datapath.
// PARAMETERS
//  MAX_ITER  255  update-step limit used by the guard (max root for a 16-bit operand)
//  CNT_W     9    width of internal update counter; must hold MAX_ITER
// PORTS
//  clk       in   1  system clock, single clock domain
//  reset     in   1  synchronous, active-high reset
//  start     in   1  job request; sampled only in IDLE
//  lteflg    in   1  datapath compare result (sq <= a)
//  busy      out  1  high while a job is in progress (state != IDLE)
//  done      out  1  one-cycle pulse; root output of datapath valid this cycle
//  dp_init   out  1  reset for sqReg/delReg only (loads sq=1, del=3); aReg/outReg stay on reset
//  ald       out  1  load operand register from sw
//  sqld      out  1  load sq <= sq + del
//  dld       out  1  load del <= del + 2
//  outld     out  1  load root <= del[10:1] - 1
//  guard_hit out  1  job ended by iteration guard (0 when guard compiled out)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, ald, sqld, dld, outld, guard_hit = 0; dp_init = 1 (dp_init = reset | INIT).
//  - States: IDLE, INIT, TEST, UPDATE, FIN. Strobes are Moore decodes of the state, except done (registered).
//  - IDLE: start=1 -> INIT; else stay. start while busy is ignored (no queueing).
//  - INIT (1 cycle): dp_init=1, ald=1 (sw captured at end of this cycle); cnt<=0; guard_hit<=0 -> TEST.
//  - TEST: lteflg=1 -> UPDATE; lteflg=0 -> FIN. lteflg reflects regs updated by the previous edge.
//  - UPDATE: sqld=1, dld=1, cnt<=cnt+1 -> TEST.
//  - FIN: outld=1 -> IDLE; done registered high the following cycle (root valid on that cycle).
//  - Latency: root r = floor(sqrt(a)); r UPDATE cycles, r+1 TEST cycles; done is 2r+4 cycles after the start edge.
//  - done cycle is in IDLE: a start there is accepted (back-to-back jobs, no gap).
//  - Reset mid-job: abort, IDLE next cycle, no done pulse, outReg cleared by reset.
//  - Counter saturates at MAX_ITER; it never wraps.
// CONFIGURATION
//  SQRT_CTRL_GUARD_EN defined: in TEST, if lteflg=1 and cnt==MAX_ITER -> FIN (not UPDATE), guard_hit<=1 until next INIT.
//   Covers a >= 65025, where sq reaches 65536 and wraps to 0 in 16 bits. del=513 then gives root 255 (correct).
//  Not defined: no guard, guard_hit tied 0; operands a >= 65025 never terminate (documented restriction;
//   requester must clamp).
// STRUCTURE
//  sqrt_pkg: state encoding localparams (IDLE..FIN), SQRT_W=16, ROOT_W=10, default MAX_ITER.
//  No sub-module: update counter and FSM are inline. Top-level wiring: dp_init to sqReg/delReg reset pins only.
// TESTING
//  a=0: start -> 0 UPDATE cycles, done 4 cycles after start, root=0, guard_hit=0.
//  a=16: root=4, 4 sqld/dld pulses, done 12 cycles after start. a=15: root=3, done 10 cycles after start.
//  a=65535 with guard: root=255, guard_hit=1, done 514 cycles after start. Without guard: not applied.
//  start held high during a=100 job: single job run; second job begins only on the done cycle.
//  Back-to-back a=9 then a=2: roots 3 then 1; sq/del re-init by dp_init (no carry-over between jobs).
//  reset asserted in UPDATE of an a=1000 job: IDLE next cycle, all strobes 0, no done pulse, root=0.

Source files
------------

// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_pkg
//  Purpose  : Shared widths, default limits and FSM state encoding for the
//             16-bit integer square-root controller.
//  Revision : 1.0  initial release
// ============================================================================
package sqrt_pkg;

    localparam int SQRT_W       = 16;
    localparam int ROOT_W       = 10;
    localparam int DEF_MAX_ITER = 255;
    localparam int DEF_CNT_W    = 9;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] INIT   = 3'd1;
    localparam logic [STATE_W-1:0] TEST   = 3'd2;
    localparam logic [STATE_W-1:0] UPDATE = 3'd3;
    localparam logic [STATE_W-1:0] FIN    = 3'd4;

endpackage : sqrt_pkg
`default_nettype wire

// File: rtl/sqrt_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_ctrl_if
//  Purpose  : Request/strobe bundle between the requester/datapath side
//             (master) and the square-root sequencer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface sqrt_ctrl_if;

    logic start;
    logic lteflg;
    logic busy;
    logic done;
    logic dp_init;
    logic ald;
    logic sqld;
    logic dld;
    logic outld;
    logic guard_hit;

    modport master (
        output start,
        output lteflg,
        input  busy,
        input  done,
        input  dp_init,
        input  ald,
        input  sqld,
        input  dld,
        input  outld,
        input  guard_hit
    );

    modport slave (
        input  start,
        input  lteflg,
        output busy,
        output done,
        output dp_init,
        output ald,
        output sqld,
        output dld,
        output outld,
        output guard_hit
    );

endinterface : sqrt_ctrl_if
`default_nettype wire

// File: rtl/sqrt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_ctrl
//  Purpose  : FSM sequencing the 16-bit integer square-root datapath
//             (operand/sq/del/root registers, sq<=a compare).
//  Option   : SQRT_CTRL_GUARD_EN enables the iteration guard for a >= 65025.
//  Revision : 1.0  initial release
// ============================================================================
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = DEF_MAX_ITER,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  wire logic     clk,
    input  wire logic     reset,
    sqrt_ctrl_if.slave    bus
);

    localparam logic [CNT_W-1:0] C_MAX_ITER = CNT_W'(MAX_ITER);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               w_guard_stop;

`ifdef SQRT_CTRL_GUARD_EN
    logic               r_guard_hit;

    // sq wraps to 0 once the root reaches 255, so the compare alone never ends the job
    assign w_guard_stop = (r_state == TEST) && bus.lteflg && (r_cnt == C_MAX_ITER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_guard_hit <= 1'b0;
        end else if (r_state == INIT) begin
            r_guard_hit <= 1'b0;
        end else if (w_guard_stop) begin
            r_guard_hit <= 1'b1;
        end
    end

    assign bus.guard_hit = r_guard_hit;
`else
    assign w_guard_stop  = 1'b0;
    assign bus.guard_hit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = INIT;
            INIT:    w_next = TEST;
            TEST: begin
                if (bus.lteflg && !w_guard_stop) begin
                    w_next = UPDATE;
                end else begin
                    w_next = FIN;
                end
            end
            UPDATE:  w_next = TEST;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Update counter saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= '0;
        end else if ((r_state == UPDATE) && (r_cnt != C_MAX_ITER)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
        end
    end

    // dp_init also follows reset so sq/del hold their seed values while held
    assign bus.dp_init = reset | (r_state == INIT);
    assign bus.busy    = (r_state != IDLE);
    assign bus.ald     = (r_state == INIT);
    assign bus.sqld    = (r_state == UPDATE);
    assign bus.dld     = (r_state == UPDATE);
    assign bus.outld   = (r_state == FIN);
    assign bus.done    = r_done;

endmodule : sqrt_ctrl
`default_nettype wire

// File: tb/tb_sqrt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_ctrl
//  Purpose  : Self-checking bench for sqrt_ctrl with a behavioural datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] sw;

    logic [15:0] dp_a;
    logic [15:0] dp_sq;
    logic [10:0] dp_del;
    logic [9:0]  dp_out;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_ctrl_if bus ();

    sqrt_ctrl #(.MAX_ITER(255), .CNT_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath driven by the controller strobes
    assign bus.lteflg = (dp_sq <= dp_a);

    always @(posedge clk) begin
        if (reset) begin
            dp_a   <= '0;
            dp_out <= '0;
        end else begin
            if (bus.ald)   dp_a   <= sw;
            if (bus.outld) dp_out <= dp_del[10:1] - 10'd1;
        end
        if (bus.dp_init) begin
            dp_sq  <= 16'd1;
            dp_del <= 11'd3;
        end else begin
            if (bus.sqld) dp_sq  <= dp_sq + {5'd0, dp_del};
            if (bus.dld)  dp_del <= dp_del + 11'd2;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_root(input int a);
        int r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    // Raises start in the current cycle and follows the job up to its done pulse
    task automatic run_job(input logic [15:0] a, input bit hold);
        int  cyc  = 0;
        int  nsq  = 0;
        int  nald = 0;
        bit  seen = 0;
        int  r    = ref_root(int'(a));
        bit  g    = (int'(a) >= 65025);
        sw        = a;
        bus.start = 1'b1;
        while (!seen && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold) bus.start = 1'b0;
            if (bus.sqld) nsq++;
            if (bus.ald)  nald++;
            if (bus.done) seen = 1'b1;
        end
        check($sformatf("done_seen a=%0d", a), 32'(seen), 32'd1);
        if (seen) begin
            check($sformatf("latency a=%0d", a), 32'(cyc), 32'(2 * r + 4));
            check($sformatf("root a=%0d", a), 32'(dp_out), 32'(r));
            check($sformatf("sqld_cnt a=%0d", a), 32'(nsq), 32'(r));
            check($sformatf("ald_cnt a=%0d", a), 32'(nald), 32'd1);
            check($sformatf("busy_at_done a=%0d", a), 32'(bus.busy), 32'd0);
`ifdef SQRT_CTRL_GUARD_EN
            check($sformatf("guard_hit a=%0d", a), 32'(bus.guard_hit), 32'(g));
`else
            check($sformatf("guard_hit a=%0d", a), 32'(bus.guard_hit), 32'd0);
`endif
        end
    endtask

    initial begin
        int ndone;
        int cyc;
        bit seen;
        reset     = 1'b1;
        bus.start = 1'b0;
        sw        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_dp_init", 32'(bus.dp_init), 32'd1);
        check("rst_ald",     32'(bus.ald),     32'd0);
        check("rst_sqld",    32'(bus.sqld),    32'd0);
        check("rst_dld",     32'(bus.dld),     32'd0);
        check("rst_outld",   32'(bus.outld),   32'd0);
        check("rst_guard",   32'(bus.guard_hit), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_dp_init", 32'(bus.dp_init), 32'd0);

        // Directed boundaries
        run_job(16'd0, 1'b0);
        @(posedge clk); #1;
        run_job(16'd16, 1'b0);
        @(posedge clk); #1;
        run_job(16'd15, 1'b0);
        @(posedge clk); #1;

        // start held for a whole job: second job begins on the done cycle
        run_job(16'd100, 1'b1);
        @(posedge clk); #1;
        check("held_restart_ald",  32'(bus.ald),  32'd1);
        check("held_restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        seen = 1'b0;
        cyc  = 1;
        while (!seen && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done) seen = 1'b1;
        end
        check("held_second_latency", 32'(cyc), 32'd24);
        check("held_second_root",    32'(dp_out), 32'd10);
        @(posedge clk); #1;

        // Back-to-back jobs with no gap
        run_job(16'd9, 1'b0);
        run_job(16'd2, 1'b0);
        @(posedge clk); #1;

`ifdef SQRT_CTRL_GUARD_EN
        run_job(16'd65535, 1'b0);
        @(posedge clk); #1;
        run_job(16'd65025, 1'b0);
        @(posedge clk); #1;
        run_job(16'd65024, 1'b0);
        @(posedge clk); #1;
`endif

        // Randomized operands
        for (int i = 0; i < 10; i++) begin
`ifdef SQRT_CTRL_GUARD_EN
            run_job(16'($urandom_range(0, 65535)), 1'b0);
`else
            run_job(16'($urandom_range(0, 65024)), 1'b0);
`endif
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        @(posedge clk); #1;

        // Reset during UPDATE aborts the job
        sw        = 16'd1000;
        bus.start = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (bus.sqld) seen = 1'b1;
        end
        check("abort_reached_update", 32'(seen), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",    32'(bus.busy),    32'd0);
        check("abort_ald",     32'(bus.ald),     32'd0);
        check("abort_sqld",    32'(bus.sqld),    32'd0);
        check("abort_dld",     32'(bus.dld),     32'd0);
        check("abort_outld",   32'(bus.outld),   32'd0);
        check("abort_done",    32'(bus.done),    32'd0);
        check("abort_dp_init", 32'(bus.dp_init), 32'd1);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("abort_no_done",   32'(ndone),    32'd0);
        check("abort_root",      32'(dp_out),   32'd0);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sqrt_ctrl
`default_nettype wire
